fp_div: RTL and testbench

//  Sequential signed fixed-point divider: QUOTIENT = a / b, two's complement Q(W_in-W_in_F).W_in_F in, Q(W_out-W_out_F).W_out_F out.

---
 rtl/fp_div.sv | 153 +++++++++++++++
 tb/tb_fp_div.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Sequential signed fixed-point divider: QUOTIENT = a / b, one quotient bit per clock,
// with a start/ready/done handshake and saturating OVERFLOW/UNDERFLOW/DIVZERO flags.
module fp_div #(
    parameter int unsigned W_in    = 16,
    parameter int unsigned W_in_F  = 14,
    parameter int unsigned W_out   = 16,
    parameter int unsigned W_out_F = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_in-1:0]  a,
    input  logic [W_in-1:0]  b,
    output logic             READY,
    output logic             DONE,
    output logic [W_out-1:0] QUOTIENT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic             DIVZERO
);

    localparam int unsigned N     = W_in + W_out_F;
    localparam int unsigned CW    = $clog2(N + 1);
    // The fraction bits of a and b cancel in a/b, so only the output fraction scales the dividend.
    localparam int unsigned SHIFT = W_out_F + W_in_F - W_in_F;

    localparam logic [N-1:0]     POS_LIM = N'((64'(1) << (W_out - 1)) - 64'(1));
    localparam logic [N-1:0]     NEG_LIM = N'(64'(1) << (W_out - 1));
    localparam logic [W_out-1:0] MAX_POS = {1'b0, {(W_out - 1){1'b1}}};
    localparam logic [W_out-1:0] MIN_NEG = {1'b1, {(W_out - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    logic             sign;
    logic             a_nz;
    logic             b_z;
    logic [W_in-1:0]  mag_b;
    logic [W_in-1:0]  rem;
    logic [N-1:0]     quo;
    logic [CW-1:0]    cnt;

    logic [W_in-1:0]  a_mag;
    logic [W_in-1:0]  b_mag;
    logic [W_in:0]    rem_sh;
    logic             fits;
    logic [W_out-1:0] res_q;
    logic             res_ovf;
    logic             res_unf;

    // Operand magnitudes as unsigned W_in-bit values; the most negative input maps exactly.
    always_comb begin
        a_mag  = a[W_in-1] ? W_in'(-a) : a;
        b_mag  = b[W_in-1] ? W_in'(-b) : b;
        rem_sh = {rem, quo[N-1]};
        fits   = (rem_sh >= {1'b0, mag_b});
    end

    // Sign application, saturation and flag selection from the finished magnitude quotient.
    always_comb begin
        res_q   = '0;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        if (b_z) begin
            if (a_nz) begin
                res_ovf = 1'b1;
                res_q   = sign ? MIN_NEG : MAX_POS;
            end
        end else if (a_nz) begin
            if (quo == '0) begin
                res_unf = 1'b1;
            end else if (!sign) begin
                if (quo > POS_LIM) begin
                    res_ovf = 1'b1;
                    res_q   = MAX_POS;
                end else begin
                    res_q = quo[W_out-1:0];
                end
            end else begin
                if (quo > NEG_LIM) begin
                    res_ovf = 1'b1;
                    res_q   = MIN_NEG;
                end else begin
                    res_q = -quo[W_out-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            READY     <= 1'b1;
            DONE      <= 1'b0;
            QUOTIENT  <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
            DIVZERO   <= 1'b0;
            sign      <= 1'b0;
            a_nz      <= 1'b0;
            b_z       <= 1'b0;
            mag_b     <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= a[W_in-1] ^ b[W_in-1];
                        a_nz  <= |a;
                        b_z   <= ~|b;
                        mag_b <= b_mag;
                        quo   <= N'(a_mag) << SHIFT;
                        rem   <= '0;
                        cnt   <= '0;
                        READY <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Restoring step: quotient bits shift in behind the consumed dividend bits.
                    if (fits) begin
                        rem <= W_in'(rem_sh - {1'b0, mag_b});
                        quo <= {quo[N-2:0], 1'b1};
                    end else begin
                        rem <= W_in'(rem_sh);
                        quo <= {quo[N-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    QUOTIENT  <= res_q;
                    OVERFLOW  <= res_ovf;
                    UNDERFLOW <= res_unf;
                    DIVZERO   <= b_z;
                    DONE      <= 1'b1;
                    READY     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    READY <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed corner cases, randomized operands against an
// arithmetic reference model, handshake/latency, back-to-back and mid-operation reset.
module tb_fp_div;

    localparam int W_in = 16, W_in_F = 14, W_out = 16, W_out_F = 14;
    localparam int LAT = W_in + W_out_F + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W_in-1:0]  a, b;
    logic             READY, DONE, OVERFLOW, UNDERFLOW, DIVZERO;
    logic [W_out-1:0] QUOTIENT;

    int checks = 0;
    int errors = 0;

    fp_div #(.W_in(W_in), .W_in_F(W_in_F), .W_out(W_out), .W_out_F(W_out_F)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .READY(READY), .DONE(DONE), .QUOTIENT(QUOTIENT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .DIVZERO(DIVZERO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: real-valued a/b scaled to the output format, truncated toward zero, then saturated.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb);
        longint av, bv, mag, lim;
        logic [15:0] q;
        logic ovf, unf, dz;
        av = longint'($signed(ma));
        bv = longint'($signed(mb));
        lim = longint'(1) << (W_out - 1);
        q = 16'h0000; ovf = 1'b0; unf = 1'b0; dz = 1'b0;
        if (bv == 0) begin
            dz = 1'b1;
            if (av > 0) begin q = 16'h7FFF; ovf = 1'b1; end
            else if (av < 0) begin q = 16'h8000; ovf = 1'b1; end
        end else if (av != 0) begin
            mag = ((av < 0 ? -av : av) << W_out_F) / (bv < 0 ? -bv : bv);
            if (mag == 0) unf = 1'b1;
            else if ((av < 0) == (bv < 0)) begin
                if (mag > lim - 1) begin q = 16'h7FFF; ovf = 1'b1; end
                else q = 16'(mag);
            end else begin
                if (mag > lim) begin q = 16'h8000; ovf = 1'b1; end
                else q = 16'(-mag);
            end
        end
        return {q, ovf, unf, dz};
    endfunction

    task automatic check_result(input string tag, input logic [15:0] ta, input logic [15:0] tb_v);
        logic [18:0] e;
        e = model(ta, tb_v);
        check({tag, "_q"}, 32'(QUOTIENT), 32'(e[18:3]));
        check({tag, "_flags"}, 32'({OVERFLOW, UNDERFLOW, DIVZERO}), 32'(e[2:0]));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!READY && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!READY) check({tag, "_ready_timeout"}, 32'(READY), 32'd1);
    endtask

    // Issue one operation, count clocks from the accepting edge until DONE, check the result.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v);
        int cyc = 0;
        wait_ready(tag);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        while (!DONE && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(LAT));
        check_result(tag, ta, tb_v);
        check({tag, "_ready"}, 32'(READY), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int cyc, c2;
        logic seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        check("rst_ready", 32'(READY), 32'd1);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_q", 32'(QUOTIENT), 32'd0);
        check("rst_flags", 32'({OVERFLOW, UNDERFLOW, DIVZERO}), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        run_op("neg_trunc", 16'h2000, 16'h9000);
        check("neg_trunc_abs", 32'(QUOTIENT), 32'hEDB7);
        run_op("sat_pos", 16'h9000, 16'hD000);
        run_op("neg_exact", 16'h8000, 16'h4000);
        run_op("underflow", 16'h0001, 16'h7FFF);
        run_op("plain", 16'h1000, 16'h2000);
        run_op("dz_pos", 16'h4000, 16'h0000);
        run_op("dz_neg", 16'hC000, 16'h0000);
        run_op("dz_zero", 16'h0000, 16'h0000);
        run_op("a_zero", 16'h0000, 16'h8000);
        run_op("sat_neg", 16'h8000, 16'h3FFF);
        run_op("min_min", 16'h8000, 16'h8000);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            if ($urandom_range(0, 1) == 0) rb = -rb;
            run_op("rand", ra, rb);
        end

        // start pulsed during CALC must be ignored
        a = 16'h1000; b = 16'h2000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 10) begin a = 16'h4000; b = 16'h0000; start = 1'b1; end
            else start = 1'b0;
        end
        check("ign_lat", 32'(cyc), 32'(LAT));
        check_result("ign", 16'h1000, 16'h2000);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (DONE) seen = 1'b1;
        end
        check("ign_no_second_done", 32'(seen), 32'd0);
        check("ign_hold_q", 32'(QUOTIENT), 32'h2000);

        // back-to-back: new start accepted in the DONE cycle
        a = 16'h2000; b = 16'h9000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("b2b_lat1", 32'(cyc), 32'(LAT));
        check_result("b2b_1", 16'h2000, 16'h9000);
        a = 16'h9000; b = 16'hD000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        c2 = 1;
        while (!DONE && c2 < 100) begin @(posedge clk); #1; c2++; end
        check("b2b_gap", 32'(c2), 32'(LAT + 1));
        check_result("b2b_2", 16'h9000, 16'hD000);

        // asynchronous reset mid-CALC
        a = 16'h4000; b = 16'h2000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1; #1;
        check("mid_rst_ready", 32'(READY), 32'd1);
        check("mid_rst_q", 32'(QUOTIENT), 32'd0);
        check("mid_rst_flags", 32'({OVERFLOW, UNDERFLOW, DIVZERO}), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (DONE) seen = 1'b1;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        run_op("after_rst", 16'h4000, 16'h4000);
        check("after_rst_abs", 32'(QUOTIENT), 32'h4000);

        @(posedge clk); #1;
        check("done_pulse", 32'(DONE), 32'd0);
        check("hold_q", 32'(QUOTIENT), 32'h4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1);
    end

endmodule
